ofdm_rx_cp_strip: RTL and testbench

//  Multi-channel OFDM RX front-end framer that sits between the ADC sample interface and the FFT.

---
 rtl/ofdm_rx_cp_strip_if.sv | 29 ++
 rtl/ofdm_rx_cp_strip.sv | 132 +++++++++++++
 tb/tb_ofdm_rx_cp_strip.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ofdm_rx_cp_strip_if.sv
// Sample-stream bundle between the ADC front end, the CP stripper and the FFT.
// The master drives the oversampled input stream; the slave drives the payload stream.
interface ofdm_rx_cp_strip_if #(
   parameter int CHANNELS     = 2,
   parameter int SAMPLE_WIDTH = 12,
   parameter int PHASE_W      = 3
);
   logic                             sym_start;
   logic [PHASE_W-1:0]               osr_phase;
   logic [CHANNELS*SAMPLE_WIDTH-1:0] in_i;
   logic [CHANNELS*SAMPLE_WIDTH-1:0] in_q;
   logic                             in_valid;
   logic [CHANNELS*SAMPLE_WIDTH-1:0] out_i;
   logic [CHANNELS*SAMPLE_WIDTH-1:0] out_q;
   logic                             out_valid;
   logic                             out_start;
   logic                             out_last;
   logic                             sym_err;

   modport master (
      output sym_start, osr_phase, in_i, in_q, in_valid,
      input  out_i, out_q, out_valid, out_start, out_last, sym_err
   );

   modport slave (
      input  sym_start, osr_phase, in_i, in_q, in_valid,
      output out_i, out_q, out_valid, out_start, out_last, sym_err
   );
endinterface

// File: rtl/ofdm_rx_cp_strip.sv
// OFDM RX framer: decimates the oversampled I/Q stream, counts symbol positions
// from the timing-sync strobe, drops the cyclic prefix and frames the payload.
module ofdm_rx_cp_strip #(
   parameter int SAMPLE_WIDTH      = 12,
   parameter int SYMBOL_LENGTH     = 320,
   parameter int RAW_SYMBOL_LENGTH = 256,
   parameter int OSR               = 5,
   parameter int CHANNELS          = 2
) (
   input logic                sys_clk,
   input logic                sys_rst,
   input logic                sys_init,
   ofdm_rx_cp_strip_if.slave  bus
);
   localparam int CP_LEN  = SYMBOL_LENGTH - RAW_SYMBOL_LENGTH;
   localparam int PHASE_W = (OSR > 1) ? $clog2(OSR) : 1;
   localparam int SC_W    = (SYMBOL_LENGTH > 1) ? $clog2(SYMBOL_LENGTH) : 1;
   localparam logic [PHASE_W-1:0] OS_MAX = PHASE_W'(OSR - 1);
   localparam logic [SC_W-1:0]    SC_MAX = SC_W'(SYMBOL_LENGTH - 1);
   localparam logic [SC_W-1:0]    SC_CP  = SC_W'(CP_LEN);

   generate
      if (RAW_SYMBOL_LENGTH > SYMBOL_LENGTH || RAW_SYMBOL_LENGTH < 1) begin : g_bad_len
         $error("RAW_SYMBOL_LENGTH must lie in 1..SYMBOL_LENGTH");
      end
      if (OSR < 1 || CHANNELS < 1) begin : g_bad_cfg
         $error("OSR and CHANNELS must be at least 1");
      end
   endgenerate

   typedef enum logic [1:0] {ST_IDLE, ST_CP, ST_DATA} state_t;
   localparam state_t ST_SYNC = (CP_LEN == 0) ? ST_DATA : ST_CP;

   state_t             state_q, state_d, state_eff;
   logic [PHASE_W-1:0] os_cnt_q, os_cnt_d, os_eff;
   logic [PHASE_W-1:0] phase_q, phase_d, phase_eff;
   logic [SC_W-1:0]    smp_cnt_q, smp_cnt_d, smp_eff;
   logic               resync, take, fwd, is_first, is_last, err;
   logic               out_valid_q, out_start_q, out_last_q, sym_err_q;
   logic               clr;

   assign clr = sys_rst | sys_init;

   // A sync beat realigns counters for that very beat, so "effective" values feed the datapath.
   always_comb begin
      resync    = bus.in_valid & bus.sym_start;
      os_eff    = os_cnt_q;
      phase_eff = phase_q;
      smp_eff   = smp_cnt_q;
      state_eff = state_q;
      if (resync) begin
         os_eff    = '0;
         phase_eff = (bus.osr_phase > OS_MAX) ? OS_MAX : bus.osr_phase;
         smp_eff   = '0;
         state_eff = ST_SYNC;
      end

      take     = bus.in_valid && (state_eff != ST_IDLE) && (os_eff == phase_eff);
      fwd      = take && (state_eff == ST_DATA);
      is_first = (smp_eff == SC_CP);
      is_last  = (smp_eff == SC_MAX);
      // Entering DATA before the first payload sample is not yet a started payload.
      err      = resync && (state_q == ST_DATA) && (smp_cnt_q != SC_CP);

      os_cnt_d  = os_cnt_q;
      phase_d   = phase_eff;
      smp_cnt_d = smp_eff;
      state_d   = state_eff;
      if (bus.in_valid) begin
         os_cnt_d = (os_eff == OS_MAX) ? '0 : os_eff + 1'b1;
      end
      if (take) begin
         if (is_last) begin
            smp_cnt_d = '0;
            state_d   = ST_SYNC;
         end else begin
            smp_cnt_d = smp_eff + 1'b1;
            if (smp_cnt_d == SC_CP) begin
               state_d = ST_DATA;
            end
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (clr) begin
         state_q     <= ST_IDLE;
         os_cnt_q    <= '0;
         phase_q     <= '0;
         smp_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_start_q <= 1'b0;
         out_last_q  <= 1'b0;
         sym_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         os_cnt_q    <= os_cnt_d;
         phase_q     <= phase_d;
         smp_cnt_q   <= smp_cnt_d;
         out_valid_q <= fwd;
         out_start_q <= fwd & is_first;
         out_last_q  <= fwd & is_last;
         sym_err_q   <= err;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
         logic [SAMPLE_WIDTH-1:0] i_q;
         logic [SAMPLE_WIDTH-1:0] q_q;

         always_ff @(posedge sys_clk) begin
            if (clr) begin
               i_q <= '0;
               q_q <= '0;
            end else if (fwd) begin
               i_q <= bus.in_i[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH];
               q_q <= bus.in_q[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            end
         end

         assign bus.out_i[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH] = i_q;
         assign bus.out_q[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH] = q_q;
      end
   endgenerate

   assign bus.out_valid = out_valid_q;
   assign bus.out_start = out_start_q;
   assign bus.out_last  = out_last_q;
   assign bus.sym_err   = sym_err_q;
endmodule

// File: tb/tb_ofdm_rx_cp_strip.sv
// Directed bench for the CP stripper: a 4-channel OSR=5 instance for framing,
// gaps, resync and reset, plus an OSR=1 instance whose payload fills the symbol.
module tb_ofdm_rx_cp_strip;
   localparam int W   = 12;
   localparam int CH  = 4;
   localparam int PW  = 3;
   localparam int WB  = 8;

   logic clk = 1'b0;
   logic rst;
   logic init;

   always #5 clk = ~clk;

   ofdm_rx_cp_strip_if #(.CHANNELS(CH), .SAMPLE_WIDTH(W),  .PHASE_W(PW)) bus_a ();
   ofdm_rx_cp_strip_if #(.CHANNELS(1),  .SAMPLE_WIDTH(WB), .PHASE_W(1))  bus_b ();

   ofdm_rx_cp_strip #(
      .SAMPLE_WIDTH(W), .SYMBOL_LENGTH(320), .RAW_SYMBOL_LENGTH(256), .OSR(5), .CHANNELS(CH)
   ) dut_a (
      .sys_clk(clk), .sys_rst(rst), .sys_init(init), .bus(bus_a)
   );

   ofdm_rx_cp_strip #(
      .SAMPLE_WIDTH(WB), .SYMBOL_LENGTH(8), .RAW_SYMBOL_LENGTH(8), .OSR(1), .CHANNELS(1)
   ) dut_b (
      .sys_clk(clk), .sys_rst(rst), .sys_init(init), .bus(bus_b)
   );

   int checks = 0;
   int errors = 0;

   // Observation state for instance A
   int cyc, vb;
   int n_out, n_start, n_last, n_err;
   int start_cyc, start_val, last_cyc, last_val, err_cyc;
   int min_gap, max_gap, prev_cyc, prev_val, seq_bad, slice_bad;

   // Observation state for instance B
   int vb_b, nb_out, nb_start, nb_last, b_last_val;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
         $display("ok   %s = %0d", tag, obs);
      else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tally_clear();
      n_out = 0; n_start = 0; n_last = 0; n_err = 0;
      start_cyc = -1; start_val = -1; last_cyc = -1; last_val = -1; err_cyc = -1;
      min_gap = 1000000; max_gap = 0; prev_cyc = -1; prev_val = 0;
      seq_bad = 0; slice_bad = 0;
   endtask

   // One clock of instance A; input ramp is the valid-beat index since the last sync.
   task automatic drive_a(input logic v, input logic s, input logic [PW-1:0] ph);
      int val;
      if (v && s) begin
         vb  = 0;
         cyc = 0;
      end
      bus_a.in_valid  = v;
      bus_a.sym_start = s;
      bus_a.osr_phase = ph;
      for (int c = 0; c < CH; c++) begin
         bus_a.in_i[c*W +: W] = W'(vb + 7*c);
         bus_a.in_q[c*W +: W] = ~W'(vb + 7*c);
      end
      @(posedge clk);
      #1;
      if (v) vb++;
      if (bus_a.out_valid === 1'b1) begin
         val = int'(bus_a.out_i[W-1:0]);
         n_out++;
         for (int c = 1; c < CH; c++)
            if (bus_a.out_i[c*W +: W] !== W'(val + 7*c)) slice_bad++;
         for (int c = 0; c < CH; c++)
            if (bus_a.out_q[c*W +: W] !== ~bus_a.out_i[c*W +: W]) slice_bad++;
         if (prev_cyc >= 0) begin
            if (cyc - prev_cyc < min_gap) min_gap = cyc - prev_cyc;
            if (cyc - prev_cyc > max_gap) max_gap = cyc - prev_cyc;
            if (bus_a.out_start !== 1'b1 && val != ((prev_val + 5) % 4096)) seq_bad++;
         end
         prev_cyc = cyc;
         prev_val = val;
         if (bus_a.out_start === 1'b1) begin
            n_start++; start_cyc = cyc; start_val = val;
         end
         if (bus_a.out_last === 1'b1) begin
            n_last++; last_cyc = cyc; last_val = val;
         end
      end
      if (bus_a.sym_err === 1'b1) begin
         n_err++; err_cyc = cyc;
      end
      cyc++;
   endtask

   task automatic drive_b(input logic v, input logic s, input logic ph);
      if (v && s) vb_b = 0;
      bus_b.in_valid  = v;
      bus_b.sym_start = s;
      bus_b.osr_phase = ph;
      bus_b.in_i      = WB'(vb_b);
      bus_b.in_q      = ~WB'(vb_b);
      @(posedge clk);
      #1;
      if (v) vb_b++;
      if (bus_b.out_valid === 1'b1) begin
         nb_out++;
         if (bus_b.out_start === 1'b1) nb_start++;
         if (bus_b.out_last === 1'b1) begin
            nb_last++; b_last_val = int'(bus_b.out_i);
         end
      end
   endtask

   initial begin
      rst = 1'b1; init = 1'b0; cyc = 0; vb = 0; vb_b = 0;
      nb_out = 0; nb_start = 0; nb_last = 0; b_last_val = -1;
      bus_b.in_valid = 1'b0; bus_b.sym_start = 1'b0; bus_b.osr_phase = 1'b0;
      bus_b.in_i = '0; bus_b.in_q = '0;
      tally_clear();

      // Power-on reset
      repeat (3) drive_a(1'b0, 1'b0, 3'd0);
      check("rst_out_valid", int'(bus_a.out_valid), 0);
      check("rst_flags", int'({bus_a.out_start, bus_a.out_last, bus_a.sym_err}), 0);
      check("rst_out_i_zero", int'(bus_a.out_i == '0), 1);
      rst = 1'b0;

      // No sync yet: nothing comes out
      tally_clear();
      repeat (20) drive_a(1'b1, 1'b0, 3'd2);
      check("idle_no_output", n_out, 0);

      // Nominal first symbol, phase 2
      tally_clear();
      drive_a(1'b1, 1'b1, 3'd2);
      repeat (1599) drive_a(1'b1, 1'b0, 3'd2);
      check("nom_n_out", n_out, 256);
      check("nom_n_start", n_start, 1);
      check("nom_start_cyc", start_cyc, 322);
      check("nom_start_val", start_val, 322);
      check("nom_n_last", n_last, 1);
      check("nom_last_cyc", last_cyc, 1597);
      check("nom_last_val", last_val, 1597);
      check("nom_min_gap", min_gap, 5);
      check("nom_max_gap", max_gap, 5);
      check("nom_seq_bad", seq_bad, 0);
      check("nom_slice_bad", slice_bad, 0);
      check("nom_n_err", n_err, 0);

      // Following symbol without a new sync
      tally_clear();
      repeat (1600) drive_a(1'b1, 1'b0, 3'd2);
      check("sym2_n_out", n_out, 256);
      check("sym2_n_last", n_last, 1);
      check("sym2_start_val", start_val, 1922);
      check("sym2_last_val", last_val, 3197);

      // Reset in the middle of a payload
      repeat (400) drive_a(1'b1, 1'b0, 3'd2);
      rst = 1'b1;
      repeat (3) drive_a(1'b1, 1'b0, 3'd2);
      check("midrst_out_valid", int'(bus_a.out_valid), 0);
      check("midrst_out_zero", int'(bus_a.out_i == '0 && bus_a.out_q == '0), 1);
      rst = 1'b0;
      tally_clear();
      repeat (2000) drive_a(1'b1, 1'b0, 3'd2);
      check("midrst_no_output", n_out, 0);

      // Gapped input: valid every other cycle
      tally_clear();
      drive_a(1'b1, 1'b1, 3'd2);
      drive_a(1'b0, 1'b0, 3'd2);
      repeat (1599) begin
         drive_a(1'b1, 1'b0, 3'd2);
         drive_a(1'b0, 1'b0, 3'd2);
      end
      check("gap_n_out", n_out, 256);
      check("gap_start_cyc", start_cyc, 644);
      check("gap_start_val", start_val, 322);
      check("gap_last_val", last_val, 1597);
      check("gap_n_last", n_last, 1);
      check("gap_min_gap", min_gap, 10);
      check("gap_max_gap", max_gap, 10);
      check("gap_seq_bad", seq_bad, 0);

      // Resync after 101 payload samples of the next symbol
      tally_clear();
      repeat (823) drive_a(1'b1, 1'b0, 3'd2);
      check("pre_resync_n_out", n_out, 101);
      check("pre_resync_n_last", n_last, 0);
      tally_clear();
      drive_a(1'b1, 1'b1, 3'd2);
      repeat (1599) drive_a(1'b1, 1'b0, 3'd2);
      check("resync_n_err", n_err, 1);
      check("resync_err_cyc", err_cyc, 0);
      check("resync_start_cyc", start_cyc, 322);
      check("resync_start_val", start_val, 322);
      check("resync_n_out", n_out, 256);
      check("resync_n_last", n_last, 1);

      // Resync inside the CP at smp_cnt=10, with out-of-range phase 7
      tally_clear();
      repeat (50) drive_a(1'b1, 1'b0, 3'd2);
      drive_a(1'b1, 1'b1, 3'd7);
      repeat (1599) drive_a(1'b1, 1'b0, 3'd2);
      check("cpsync_n_err", n_err, 0);
      check("cpsync_start_cyc", start_cyc, 324);
      check("cpsync_start_val", start_val, 324);
      check("cpsync_last_val", last_val, 1599);
      check("cpsync_n_out", n_out, 256);

      // Soft restart mid-payload
      repeat (400) drive_a(1'b1, 1'b0, 3'd2);
      init = 1'b1;
      drive_a(1'b1, 1'b0, 3'd2);
      init = 1'b0;
      check("init_out_valid", int'(bus_a.out_valid), 0);
      check("init_out_zero", int'(bus_a.out_i == '0), 1);
      tally_clear();
      repeat (400) drive_a(1'b1, 1'b0, 3'd2);
      check("init_no_output", n_out, 0);
      bus_a.in_valid = 1'b0;

      // OSR=1, payload covers the whole symbol
      drive_b(1'b1, 1'b1, 1'b1);
      check("b_first_valid", int'(bus_b.out_valid), 1);
      check("b_first_start", int'(bus_b.out_start), 1);
      check("b_first_val", int'(bus_b.out_i), 0);
      repeat (15) drive_b(1'b1, 1'b0, 1'b0);
      check("b_n_out", nb_out, 16);
      check("b_n_start", nb_start, 2);
      check("b_n_last", nb_last, 2);
      check("b_last_val", b_last_val, 15);
      repeat (3) drive_b(1'b1, 1'b0, 1'b0);
      drive_b(1'b1, 1'b1, 1'b0);
      check("b_resync_err", int'(bus_b.sym_err), 1);
      check("b_resync_start", int'(bus_b.out_start), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
